multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. It decodes the 6-bit instruction opcode and sequences each instruction through fetch, decode, execute, memory and write-back, one state per clock. It drives the 2-bit ALUOp that the ALU control block expands, together with the Function field, into the 4-bit ALU operation. It also drives every multiplexer select and write enable in the datapath, and stalls on a memory-ready handshake.

## Interface
- none: no parameters; all encodings are fixed below.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; forces state to FETCH.
- Opcode  input  6  instruction[31:26] from the instruction register; sampled only in DECODE.
- MemReady  input  1  memory handshake; 1 means the current memory access completes this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath enables/selects.
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  output  2  00 add, 01 subtract, 10 use Function field.
- ALUSrcB  output  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- Illegal  output  1  unsupported opcode flag.
- State  output  4  current state code, for debug.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Outputs are decoded combinationally from State. Any output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, IRWrite=MemReady, PCWrite=MemReady.
- DECODE: ALUSrcB=11, ALUOp=00.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: MemRead=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1.
- MEMWR: MemWrite=1, IorD=1.
- EXEC: ALUSrcA=1, ALUOp=10.
- RTWB: RegWrite=1, RegDst=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
- ADDIEX: ALUSrcA=1, ALUSrcB=10.
- ADDIWB: RegWrite=1.
- Transitions:
  - FETCH→DECODE on MemReady; otherwise hold.
  - DECODE→MEMADR when Opcode is 100011 (lw) or 101011 (sw).
  - DECODE→EXEC when Opcode is 000000.
  - DECODE→BRANCH when Opcode is 000100.
  - DECODE→JUMP when Opcode is 000010.
  - DECODE→ADDIEX when Opcode is 001000 (macro-gated).
  - DECODE→FETCH for any other opcode.
  - MEMADR→MEMRD for lw; MEMADR→MEMWR for sw.
  - MEMRD→MEMWB on MemReady; otherwise hold.
  - MEMWR→FETCH on MemReady; otherwise hold.
  - EXEC→RTWB→FETCH.
  - ADDIEX→ADDIWB→FETCH.
  - BRANCH→FETCH and JUMP→FETCH.
- Illegal=1 only while in DECODE with an unsupported Opcode. It is a one-cycle pulse, and the FSM then returns to FETCH with no architectural write.
- MemRead and MemWrite stay high for the whole stall. IRWrite and PCWrite in FETCH pulse only in the MemReady cycle.

## Timing
- Reset: State=0 (FETCH) immediately, with no clock required. While reset is high, IRWrite=0 and PCWrite=0 regardless of MemReady. Outputs otherwise follow the FETCH decode: MemRead=1, ALUSrcB=01, all other outputs 0.
- Reset asserted mid-instruction abandons the instruction. The first post-reset rising edge with MemReady=1 moves the FSM to DECODE.
- Cycles per instruction with MemReady held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each stalled memory cycle adds 1.
- Opcode is don't-care outside DECODE.
- MemReady is don't-care outside FETCH, MEMRD and MEMWR.

## Configuration
- MULTICYCLE_ADDI_EN defined: opcode 001000 follows DECODE→ADDIEX→ADDIWB→FETCH, and states 10 and 11 are reachable.
- MULTICYCLE_ADDI_EN undefined: opcode 001000 is unsupported (Illegal pulse, return to FETCH), and states 10 and 11 are not implemented. An unreachable state code returns to FETCH on the next edge.

## Test plan
- Reset with MemReady=1 and Opcode=100011 → State sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. IRWrite=1 and PCWrite=1 only in state 0.
- sw (101011) with MemReady=0 for 3 cycles in MEMWR → MemWrite=1 for 4 cycles, then FETCH.
- R-type (000000) → ALUOp=10 in EXEC, then RegDst=1 and RegWrite=1 in RTWB; 4 cycles total. beq (000100) → PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH.
- Opcode 111111 → Illegal=1 for exactly 1 cycle in DECODE, and State=0 on the next cycle. With the macro undefined, 001000 gives the same response; with it defined, 001000 runs ADDIEX with ALUSrcB=10, then ADDIWB with RegWrite=1.
- Assert reset in MEMRD → State=0 before the next edge, and IRWrite=0 and PCWrite=0 while reset is high.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Each instruction steps through fetch, decode, execute, memory and write-back,
// one state per clock. Memory states stall until MemReady is high.
// Outputs are decoded combinationally from the current state. In FETCH,
// IRWrite and PCWrite also depend on MemReady.
// Optional feature: define MULTICYCLE_ADDI_EN to add the addi path (states 10, 11).
// Without it, opcode 001000 is treated as unsupported.

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       Illegal,
  output logic [3:0] State
);

  // Opcode values recognised in DECODE
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  // ALUOp encodings
  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluSub  = 2'b01;
  localparam logic [1:0] AluFunc = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PcAluResult = 2'b00;
  localparam logic [1:0] PcAluOut    = 2'b01;
  localparam logic [1:0] PcJump      = 2'b10;

  // Without the addi feature, codes 10 and 11 are left undefined in the enum.
`ifdef MULTICYCLE_ADDI_EN
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRtWb   = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;
`else
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRtWb   = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;
`endif

  state_e r_state;
  // Remembers whether the memory instruction decoded is a store, since
  // Opcode is only valid during DECODE.
  logic   r_is_store;

  logic   w_op_lw;
  logic   w_op_sw;
  logic   w_op_rtype;
  logic   w_op_beq;
  logic   w_op_j;
  logic   w_op_addi;
  logic   w_op_supported;
  state_e w_decode_next;

  assign w_op_lw    = (Opcode == OpLw);
  assign w_op_sw    = (Opcode == OpSw);
  assign w_op_rtype = (Opcode == OpRType);
  assign w_op_beq   = (Opcode == OpBeq);
  assign w_op_j     = (Opcode == OpJ);
`ifdef MULTICYCLE_ADDI_EN
  assign w_op_addi  = (Opcode == OpAddi);
`else
  assign w_op_addi  = 1'b0;
`endif

  assign w_op_supported = w_op_lw | w_op_sw | w_op_rtype | w_op_beq | w_op_j | w_op_addi;

  // Select the DECODE successor state from the opcode class
  always_comb begin
    w_decode_next = StFetch;
    if (w_op_lw || w_op_sw) begin
      w_decode_next = StMemAdr;
    end else if (w_op_rtype) begin
      w_decode_next = StExec;
    end else if (w_op_beq) begin
      w_decode_next = StBranch;
    end else if (w_op_j) begin
      w_decode_next = StJump;
`ifdef MULTICYCLE_ADDI_EN
    end else if (w_op_addi) begin
      w_decode_next = StAddiEx;
`endif
    end
  end

  // State register and transition logic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StFetch;
      r_is_store <= 1'b0;
    end else begin
      case (r_state)
        StFetch: begin
          if (MemReady) r_state <= StDecode;
        end
        StDecode: begin
          r_is_store <= w_op_sw;
          r_state    <= w_decode_next;
        end
        StMemAdr: r_state <= r_is_store ? StMemWr : StMemRd;
        StMemRd: begin
          if (MemReady) r_state <= StMemWb;
        end
        StMemWb: r_state <= StFetch;
        StMemWr: begin
          if (MemReady) r_state <= StFetch;
        end
        StExec:   r_state <= StRtWb;
        StRtWb:   r_state <= StFetch;
        StBranch: r_state <= StFetch;
        StJump:   r_state <= StFetch;
`ifdef MULTICYCLE_ADDI_EN
        StAddiEx: r_state <= StAddiWb;
        StAddiWb: r_state <= StFetch;
`endif
        // Unreachable codes recover to FETCH
        default:  r_state <= StFetch;
      endcase
    end
  end

  // Decode the datapath controls from the current state
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PcAluResult;
    ALUOp       = AluAdd;
    ALUSrcB     = SrcBReg;
    Illegal     = 1'b0;
    case (r_state)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBFour;
        ALUOp   = AluAdd;
        // Writes fire only when the fetch completes. They are held off during
        // reset, because the state is forced to FETCH asynchronously.
        IRWrite = MemReady & ~reset;
        PCWrite = MemReady & ~reset;
      end
      StDecode: begin
        ALUSrcB = SrcBImmSh2;
        ALUOp   = AluAdd;
        Illegal = ~w_op_supported;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluFunc;
      end
      StRtWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = AluSub;
        PCWriteCond = 1'b1;
        PCSource    = PcAluOut;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PcJump;
      end
`ifdef MULTICYCLE_ADDI_EN
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign State = r_state;

endmodule
